hazard_control_unit: RTL

Pipeline hazard controller for the 16-bit six-stage pipeline (IF, ID, EX1, EX2, MEM, WB). It covers the hazards that operand forwarding cannot resolve:
- load-use stalls when EX1 needs a load result still in EX2;
- full freezes while the data memory is not ready;
- flushes of younger stages on a taken branch resolved in EX2.

A watchdog FSM halts the pipeline on a hung memory access. Saturating counters record stall, wait and flush activity.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_control_unit_sat_counter.sv | 47 ++++
 rtl/hazard_control_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the six-stage pipeline hazard control:
//   - hcu_state_e : watchdog FSM states (RUN, WAIT, HALT)
//   - REG_R0      : architectural zero register (never a real dependency)
//   - fwd_sel_e   : operand forwarding mux select, shared with forwarding logic
//   - src_hit()   : "this consumer source really depends on that producer rd"
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HALT = 2'b10
  } hcu_state_e;

  localparam logic [3:0] REG_R0 = 4'd0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_EX2  = 2'b10
  } fwd_sel_e;

  // True when a source operand is actually read and names the producer's rd.
  function automatic logic src_hit(input logic       uses,
                                   input logic [3:0] rs,
                                   input logic [3:0] rd);
    return uses & (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that adds one per inc_i cycle and sticks at all ones.
// clr_i is a synchronous clear and wins over a same-cycle increment.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   inc_i       : count this cycle
//   clr_i       : synchronous clear
//   count_o     : registered count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear first, then saturating increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {W{1'b0}};
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Stall / freeze / flush control for the 16-bit six-stage pipeline
// (IF, ID, EX1, EX2, MEM, WB), with a memory-wait watchdog and activity
// counters.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   idex_* (valid, rs1/rs2, uses_rs*)  : EX1 instruction operands
//   exmem_* (valid, reg_write, mem_to_reg, rd, branch_taken) : EX2 instruction
//   mem_req, mem_ready                 : MEM stage data access handshake
//   perf_clr                           : synchronous clear of the counters
//   pc/ifid/idex/exmem_stall           : hold pipeline registers
//   exmem_bubble, memwb_bubble         : insert NOPs
//   ifid_flush, idex_flush             : squash younger instructions
//   mem_timeout                        : sticky watchdog flag
//   stall_cnt, wait_cnt, flush_cnt     : saturating event counters
// Control outputs are combinational from inputs and registered state.
// -----------------------------------------------------------------------------
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_valid,
  input  logic [3:0]       idex_rs1,
  input  logic [3:0]       idex_rs2,
  input  logic             idex_uses_rs1,
  input  logic             idex_uses_rs2,
  input  logic             exmem_valid,
  input  logic             exmem_reg_write,
  input  logic             exmem_mem_to_reg,
  input  logic [3:0]       exmem_rd,
  input  logic             exmem_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Last wait-counter value before the watchdog fires.
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

  hcu_state_e  state_q, state_d;
  logic [15:0] wait_len_q, wait_len_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic load_use_s;
  logic mem_busy_s;
  logic redirect_s;
  logic in_halt_s;
  logic stall_ev_s;
  logic wait_ev_s;
  logic flush_ev_s;

  assign load_use_s = idex_valid & exmem_valid & exmem_reg_write & exmem_mem_to_reg &
                      (exmem_rd != REG_R0) &
                      (src_hit(idex_uses_rs1, idex_rs1, exmem_rd) |
                       src_hit(idex_uses_rs2, idex_rs2, exmem_rd));
  assign mem_busy_s = mem_req & ~mem_ready;
  assign redirect_s = exmem_valid & exmem_branch_taken;

  // Any encoding other than RUN/WAIT is treated as halted so a corrupted
  // state register freezes the pipeline instead of letting it run.
  assign in_halt_s  = (state_q != ST_RUN) && (state_q != ST_WAIT);

  assign wait_ev_s  = ~in_halt_s & mem_busy_s;
  assign flush_ev_s = ~in_halt_s & ~mem_busy_s & redirect_s;
  assign stall_ev_s = ~in_halt_s & ~mem_busy_s & ~redirect_s & load_use_s;

  // Prioritised control outputs: freeze > redirect flush > load-use stall.
  // A redirect held during a freeze stays in EX2 and fires afterwards.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    exmem_stall  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    if (in_halt_s || mem_busy_s) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_stall  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (redirect_s) begin
      // The bubble kills the EX1 instruction; a load-use on it is moot.
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_bubble = 1'b1;
    end else if (load_use_s) begin
      // One cycle suffices: next cycle the load is in MEM and forwards.
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_bubble = 1'b1;
    end else begin
      pc_stall     = 1'b0;
    end
  end

  // Watchdog next-state, wait-length and sticky timeout logic.
  always_comb begin
    state_d       = state_q;
    wait_len_d    = wait_len_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mem_busy_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (mem_busy_s && (wait_len_q == WAIT_LAST)) begin
          state_d = ST_HALT;
        end else if (mem_busy_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    // Held while halted so it never wraps on an endless hang.
    if (in_halt_s) begin
      wait_len_d = wait_len_q;
    end else if (mem_busy_s) begin
      wait_len_d = wait_len_q + 16'd1;
    end else begin
      wait_len_d = 16'd0;
    end
    if (state_d == ST_HALT) begin
      mem_timeout_d = 1'b1;
    end else begin
      mem_timeout_d = mem_timeout_q;
    end
  end

  // Watchdog state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_len_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_len_q    <= wait_len_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (stall_ev_s),
    .clr_i   (perf_clr),
    .count_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (wait_ev_s),
    .clr_i   (perf_clr),
    .count_o (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (flush_ev_s),
    .clr_i   (perf_clr),
    .count_o (flush_cnt)
  );

endmodule
